// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Core-wide basic types shared by the pipeline and memory-side blocks.
// No ports; provides word_t, the architectural 32-bit word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/memreq_pkg.sv
// memreq_pkg
// Shared definitions for the MEM-stage data-memory request controller:
// the controller state encoding and the store-conditional result words.
// No ports.
package memreq_pkg;

  import cpu_types_pkg::*;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    SCFAIL = 3'd3,
    DONE   = 3'd4
  } memreq_state_t;

  localparam word_t SC_SUCCESS = 32'd1;
  localparam word_t SC_FAIL    = 32'd0;

endpackage : memreq_pkg

// File: rtl/ll_sc_link_reg.sv
// ll_sc_link_reg
// Load-linked / store-conditional link register. Holds one word address
// and a valid bit. Set by a completing LL, cleared by a completing store to
// the linked word, and cleared by a coherence snoop to the linked word.
// Ports:
//   CLK, RST            clock, async active-high reset
//   set_en, set_addr    LL completion: link set_addr (word address)
//   clr_en, clr_addr    store completion: drop link if clr_addr is linked
//   snoop_inv, snoop_addr  invalidate from the other core (word address)
//   req_addr            word address of the request being decoded
//   link_valid          link currently held
//   req_match           link held and req_addr is the linked word
//   snoop_hit           this cycle's snoop invalidates the held link
module ll_sc_link_reg #(
  parameter int AW = 30
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          snoop_inv,
  input  logic [AW-1:0] snoop_addr,
  input  logic [AW-1:0] req_addr,
  output logic          link_valid,
  output logic          req_match,
  output logic          snoop_hit
);

  logic [AW-1:0] link_addr;

  assign snoop_hit = snoop_inv && link_valid && (snoop_addr == link_addr);
  assign req_match = link_valid && (req_addr == link_addr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set_en) begin
      // A snoop to the word being linked in the same cycle wins.
      link_addr  <= set_addr;
      link_valid <= !(snoop_inv && (snoop_addr == set_addr));
    end else if (snoop_hit || (clr_en && (clr_addr == link_addr))) begin
      link_valid <= 1'b0;
    end
  end

endmodule : ll_sc_link_reg

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl
// MEM-stage data-memory request controller. Accepts a decoded load/store
// (with LL/SC qualifiers) from the EX/MEM latch, holds the dcache request
// until dhit, maintains the LL/SC link and returns load data or the SC
// result word on rdata with a one-cycle done pulse.
// Optional build macro MEMREQ_TIMEOUT_EN adds a wait-for-dhit watchdog that
// abandons a request after TIMEOUT_CYCLES cycles and pulses err with done.
// Ports:
//   CLK, RST                  clock, async active-high reset
//   req_valid, dR_REQ, dW_REQ, ll, sc, addr, wdata   request from MEM stage
//   dhit, dmemload            dcache completion and read data
//   snoop_inv, snoop_addr     coherence invalidate from the other core
//   dmemREN, dmemWEN, dmemaddr, dmemstore   dcache request
//   rdata, done, busy, err    result, completion pulse, stall, timeout
//   link_valid                LL/SC link held
//
// state  | meaning
// IDLE   | waiting for a request; accepts in the same cycle it appears
// RD     | read held on dcache until dhit
// WR     | write held on dcache until dhit (plain store or linked SC)
// SCFAIL | SC without a link, or link lost before dhit; writes rdata=0
// DONE   | done pulse, result on rdata
module dmem_req_ctrl
  import memreq_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              dR_REQ,
  input  logic              dW_REQ,
  input  logic              ll,
  input  logic              sc,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              link_valid,
  output logic              err
);

  localparam int LA_W = WORD_W - 2;

  memreq_state_t     state, state_nxt;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic              ll_q, sc_q;
  logic              accept;
  logic              req_match, snoop_hit;
  logic              link_set, store_clr;
  logic              sc_lost;
  logic              timeout;
  logic              unused_snoop_bits;

  assign accept    = (state == IDLE) && req_valid && (dR_REQ || dW_REQ);
  assign link_set  = (state == RD) && dhit && ll_q;
  assign store_clr = (state == WR) && dhit;
  // dhit in the snoop cycle still lets the SC complete.
  assign sc_lost   = (state == WR) && sc_q && !dhit && snoop_hit;

  // Links are tracked per word; byte offset bits never take part.
  assign unused_snoop_bits = ^snoop_addr[1:0];

  ll_sc_link_reg #(
    .AW(LA_W)
  ) u_link (
    .CLK       (CLK),
    .RST       (RST),
    .set_en    (link_set),
    .set_addr  (addr_q[WORD_W-1:2]),
    .clr_en    (store_clr),
    .clr_addr  (addr_q[WORD_W-1:2]),
    .snoop_inv (snoop_inv),
    .snoop_addr(snoop_addr[WORD_W-1:2]),
    .req_addr  (addr[WORD_W-1:2]),
    .link_valid(link_valid),
    .req_match (req_match),
    .snoop_hit (snoop_hit)
  );

`ifdef MEMREQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_q;

  // Down-counter loaded outside RD/WR; terminal count on the last allowed
  // wait cycle. A lost SC takes the SCFAIL path instead.
  assign timeout = ((state == RD) || (state == WR)) && !dhit && !sc_lost &&
                   (to_cnt == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt <= CNT_LOAD;
      to_q   <= 1'b0;
    end else begin
      if ((state == RD) || (state == WR)) to_cnt <= to_cnt - 1'b1;
      else                                to_cnt <= CNT_LOAD;
      to_q <= timeout;
    end
  end

  assign err = (state == DONE) && to_q;
`else
  // Without the watchdog the controller waits on dhit indefinitely.
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dR_REQ)               state_nxt = RD;
          else if (!sc || req_match) state_nxt = WR;
          else                      state_nxt = SCFAIL;
        end
      end
      RD:      if (dhit || timeout) state_nxt = DONE;
      WR: begin
        if (dhit || timeout) state_nxt = DONE;
        else if (sc_lost)    state_nxt = SCFAIL;
      end
      SCFAIL:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    done    = 1'b0;
    busy    = accept;
    case (state)
      RD: begin
        dmemREN = 1'b1;
        busy    = 1'b1;
      end
      WR: begin
        dmemWEN = 1'b1;
        busy    = 1'b1;
      end
      SCFAIL:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign dmemaddr  = addr_q;
  assign dmemstore = wdata_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ll_q    <= 1'b0;
      sc_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        ll_q    <= ll;
        sc_q    <= sc;
      end
      case (state)
        RD:      if (dhit) rdata <= dmemload;
        WR:      if (dhit && sc_q) rdata <= WORD_W'(SC_SUCCESS);
        SCFAIL:  rdata <= WORD_W'(SC_FAIL);
        default: ;
      endcase
    end
  end

endmodule : dmem_req_ctrl

// File: tb/tb_dmem_req_ctrl.sv
module tb_dmem_req_ctrl;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, dR_REQ, dW_REQ, ll, sc;
  logic [W-1:0]  addr, wdata;
  logic          dhit;
  logic [W-1:0]  dmemload;
  logic          snoop_inv;
  logic [W-1:0]  snoop_addr;
  logic          dmemREN, dmemWEN;
  logic [W-1:0]  dmemaddr, dmemstore, rdata;
  logic          done, busy, link_valid, err;

  int checks = 0;
  int errors = 0;

  // Reference state: link register and last result, per the architectural rules.
  logic          m_lv;
  logic [31:0]   m_la;
  logic [31:0]   m_rdata;

  dmem_req_ctrl #(
    .WORD_W        (W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .dR_REQ    (dR_REQ),
    .dW_REQ    (dW_REQ),
    .ll        (ll),
    .sc        (sc),
    .addr      (addr),
    .wdata     (wdata),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .snoop_inv (snoop_inv),
    .snoop_addr(snoop_addr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .link_valid(link_valid),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    req_valid = 1'b0;
    dR_REQ    = 1'b0;
    dW_REQ    = 1'b0;
    ll        = 1'b0;
    sc        = 1'b0;
    dhit      = 1'b0;
    snoop_inv = 1'b0;
  endtask

  // op: 0 lw, 1 ll, 2 sw, 3 sc, 4 dR_REQ and dW_REQ together.
  // lat: wait cycles in RD/WR before the dhit cycle.
  // snoop_at: cycle (0 = request cycle) carrying a snoop, or -1 for none.
  task automatic run_txn(input int op, input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input int snoop_at_in,
                         input logic [31:0] sa, input logic [31:0] ld);
    bit   is_rd, is_ll, is_sc;
    int   kind;   // 0 read, 1 write completes, 2 SC rejected, 3 SC loses link in WR
    int   endc, snoop_at;
    bit   exp_ren, exp_wen, exp_busy, exp_done;
    logic        n_lv;
    logic [31:0] n_la, n_rd;
    is_rd    = (op == 0) || (op == 1) || (op == 4);
    is_ll    = (op == 1);
    is_sc    = (op == 3);
    snoop_at = snoop_at_in;
    if (is_rd)                                             kind = 0;
    else if (is_sc && !(m_lv && m_la[31:2] == a[31:2]))    kind = 2;
    else if (is_sc && snoop_at >= 1 && snoop_at <= lat && sa[31:2] == a[31:2]) kind = 3;
    else                                                   kind = 1;
    if (kind == 2 && snoop_at > 1) snoop_at = 1;
    case (kind)
      2:       endc = 2;
      3:       endc = snoop_at + 2;
      default: endc = lat + 2;
    endcase

    n_lv = m_lv;
    n_la = m_la;
    n_rd = m_rdata;
    if (snoop_at >= 1 && n_lv && sa[31:2] == m_la[31:2]) n_lv = 1'b0;
    case (kind)
      0: begin
        n_rd = ld;
        if (is_ll) begin
          n_la = a;
          n_lv = !(snoop_at == lat + 1 && sa[31:2] == a[31:2]);
        end
      end
      1: begin
        if (n_la[31:2] == a[31:2]) n_lv = 1'b0;
        if (is_sc) n_rd = 32'd1;
      end
      default: n_rd = 32'd0;
    endcase

    for (int c = 0; c <= endc; c++) begin
      @(posedge CLK);
      #1;
      idle_inputs();
      if (c == 0) begin
        req_valid = 1'b1;
        dR_REQ    = is_rd;
        dW_REQ    = !is_rd || (op == 4);
        ll        = is_ll;
        sc        = is_sc;
        addr      = a;
        wdata     = wd;
      end else begin
        addr  = $urandom;
        wdata = $urandom;
      end
      if ((kind == 0 || kind == 1) && c == lat + 1) begin
        dhit     = 1'b1;
        dmemload = ld;
      end else begin
        dmemload = $urandom;
      end
      if (c == snoop_at) begin
        snoop_inv  = 1'b1;
        snoop_addr = sa;
      end else begin
        snoop_addr = $urandom;
      end
      @(negedge CLK);
      exp_ren  = (kind == 0) && c >= 1 && c <= lat + 1;
      exp_wen  = ((kind == 1) && c >= 1 && c <= lat + 1) ||
                 ((kind == 3) && c >= 1 && c <= snoop_at);
      exp_busy = c < endc;
      exp_done = c == endc;
      checks++;
      if (dmemREN !== exp_ren) begin
        errors++;
        $display("FAIL ren op=%0d c=%0d: got %b expected %b", op, c, dmemREN, exp_ren);
      end
      checks++;
      if (dmemWEN !== exp_wen) begin
        errors++;
        $display("FAIL wen op=%0d c=%0d: got %b expected %b", op, c, dmemWEN, exp_wen);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy op=%0d c=%0d: got %b expected %b", op, c, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done op=%0d c=%0d: got %b expected %b", op, c, done, exp_done);
      end
      if (exp_ren || exp_wen) begin
        checks++;
        if (dmemaddr !== a) begin
          errors++;
          $display("FAIL dmemaddr op=%0d c=%0d: got %h expected %h", op, c, dmemaddr, a);
        end
      end
      if (exp_wen) begin
        checks++;
        if (dmemstore !== wd) begin
          errors++;
          $display("FAIL dmemstore op=%0d c=%0d: got %h expected %h", op, c, dmemstore, wd);
        end
      end
      if (exp_done) begin
        checks++;
        if (rdata !== n_rd) begin
          errors++;
          $display("FAIL rdata op=%0d addr=%h: got %h expected %h", op, a, rdata, n_rd);
        end
        checks++;
        if (link_valid !== n_lv) begin
          errors++;
          $display("FAIL link_valid op=%0d addr=%h: got %b expected %b", op, a, link_valid, n_lv);
        end
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL err op=%0d: got %b expected 0", op, err);
        end
      end
    end
    m_lv    = n_lv;
    m_la    = n_la;
    m_rdata = n_rd;
  endtask

  task automatic pulse_snoop(input logic [31:0] sa);
    @(posedge CLK);
    #1;
    idle_inputs();
    snoop_inv  = 1'b1;
    snoop_addr = sa;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL snoop_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    if (m_lv && sa[31:2] == m_la[31:2]) m_lv = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    addr = '0; wdata = '0; dmemload = '0; snoop_addr = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    m_lv = 1'b0; m_la = '0; m_rdata = '0;
    @(negedge CLK);
    checks++;
    if ({dmemREN, dmemWEN, done, busy, link_valid, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {dmemREN, dmemWEN, done, busy, link_valid, err});
    end
    checks++;
    if (rdata !== '0 || dmemaddr !== '0 || dmemstore !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h store=%h expected 0",
               rdata, dmemaddr, dmemstore);
    end
  endtask

  task automatic test_load();
    run_txn(0, 32'h100, 32'h0, 2, -1, 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_ll_sc();
    run_txn(1, 32'h200, 32'h0, 1, -1, 32'h0, 32'h0000_0077);
    run_txn(3, 32'h200, 32'h5, 1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_snoop_break();
    run_txn(1, 32'h200, 32'h0, 0, -1, 32'h0, 32'h1111_2222);
    pulse_snoop(32'h200);
    run_txn(3, 32'h200, 32'h5, 1, -1, 32'h0, 32'h0);
  endtask

  task automatic test_mid_sc_snoop();
    run_txn(1, 32'h200, 32'h0, 0, -1, 32'h0, 32'h3333_4444);
    run_txn(3, 32'h200, 32'h6, 3, 1, 32'h200, 32'h0);
    run_txn(1, 32'h200, 32'h0, 0, -1, 32'h0, 32'h5555_6666);
    run_txn(3, 32'h201, 32'h7, 2, 3, 32'h202, 32'h0);
  endtask

  task automatic test_both_req();
    run_txn(4, 32'h180, 32'hCAFE_F00D, 1, -1, 32'h0, 32'h0BAD_CAFE);
  endtask

  task automatic test_back_to_back();
    run_txn(2, 32'h104, 32'hA5A5_A5A5, 0, -1, 32'h0, 32'h0);
    run_txn(0, 32'h104, 32'h0, 0, -1, 32'h0, 32'h1234_5678);
    run_txn(1, 32'h300, 32'h0, 0, 1, 32'h300, 32'h9);
  endtask

  task automatic test_reset_mid_rd();
    run_txn(1, 32'h300, 32'h0, 0, -1, 32'h0, 32'h0000_1234);
    @(posedge CLK);
    #1;
    idle_inputs();
    req_valid = 1'b1;
    dR_REQ    = 1'b1;
    addr      = 32'h400;
    @(posedge CLK);
    #1;
    idle_inputs();
    @(negedge CLK);
    checks++;
    if (dmemREN !== 1'b1 || link_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got ren=%b link=%b expected 1 1", dmemREN, link_valid);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (dmemREN !== 1'b0 || link_valid !== 1'b0 || busy !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL async_reset: got ren=%b link=%b busy=%b rdata=%h expected 0",
               dmemREN, link_valid, busy, rdata);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_lv = 1'b0; m_la = '0; m_rdata = '0;
  endtask

  task automatic test_random();
    logic [31:0] bases [4];
    int          r, op, lat, snp;
    logic [31:0] a, sa;
    bases = '{32'h100, 32'h104, 32'h200, 32'h300};
    for (int t = 0; t < 60; t++) begin
      r  = $urandom_range(0, 9);
      op = (r < 2) ? 0 : (r < 5) ? 1 : (r < 6) ? 2 : (r < 9) ? 3 : 4;
      a  = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      sa = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      lat = $urandom_range(0, 4);
      snp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat + 1)) : -1;
      if ($urandom_range(0, 5) == 0) pulse_snoop(sa);
      run_txn(op, a, $urandom, lat, snp, sa, $urandom);
    end
  endtask

`ifdef MEMREQ_TIMEOUT_EN
  task automatic test_timeout();
    bit exp_ren, exp_done;
    for (int c = 0; c <= 9; c++) begin
      @(posedge CLK);
      #1;
      idle_inputs();
      if (c == 0) begin
        req_valid = 1'b1;
        dR_REQ    = 1'b1;
        addr      = 32'h500;
      end
      @(negedge CLK);
      exp_ren  = c >= 1 && c <= 8;
      exp_done = c == 9;
      checks++;
      if (dmemREN !== exp_ren || done !== exp_done || err !== exp_done) begin
        errors++;
        $display("FAIL timeout c=%0d: got ren=%b done=%b err=%b expected %b %b %b",
                 c, dmemREN, done, err, exp_ren, exp_done, exp_done);
      end
    end
    checks++;
    if (rdata !== m_rdata || link_valid !== m_lv) begin
      errors++;
      $display("FAIL timeout_hold: got rdata=%h link=%b expected %h %b",
               rdata, link_valid, m_rdata, m_lv);
    end
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (dmemREN !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got ren=%b err=%b expected 0 0", dmemREN, err);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_ll_sc();
    test_snoop_break();
    test_mid_sc_snoop();
    test_both_req();
    test_back_to_back();
    test_reset_mid_rd();
`ifdef MEMREQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dmem_req_ctrl
